row_decompressor: RTL and testbench

Inverse of RowCompressor. It accepts a compressed row and rebuilds the full uncompressed row of MAX_R_SIZE words, with zeros restored in their original lanes. A compressed row is a presence mask followed by its nonzero words, sent one word at a time. It sits on the read side of the redundancy buffer and feeds downstream PEs one full row per handshake.

---
 rtl/rc_pkg.sv | 20 ++
 rtl/rc_lowest_set_finder.sv | 30 +++
 rtl/row_decompressor.sv | 116 +++++++++++
 tb/tb_row_decompressor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc_pkg
// Description : Shared row-compression definitions (word size, row size,
//               lane-index width and the decompressor state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package rc_pkg;

  localparam int WORD_WIDTH   = 8;
  localparam int MAX_R_SIZE   = 4;
  localparam int R_DIST_WIDTH = 2;

  // Decompressor FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rc_lowest_set_finder.sv
`default_nettype none
// ============================================================================
// Module      : rc_lowest_set_finder
// Description : Combinational priority encoder returning the index of the
//               lowest set bit of a mask, plus a flag for "any bit set".
// Revision    : 1.0 - initial release
// ============================================================================
module rc_lowest_set_finder #(
  parameter int MAX_R_SIZE   = rc_pkg::MAX_R_SIZE,
  parameter int R_DIST_WIDTH = rc_pkg::R_DIST_WIDTH
) (
  input  logic [MAX_R_SIZE-1:0]   mask,
  output logic [R_DIST_WIDTH-1:0] idx,
  output logic                    any
);

  // Scan from the top lane down so the lowest set lane wins last
  always_comb begin
    idx = '0;
    for (int i = MAX_R_SIZE - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = R_DIST_WIDTH'(i);
      end
    end
  end

  assign any = |mask;

endmodule
`default_nettype wire

// File: rtl/row_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : row_decompressor
// Description : Rebuilds a full row of MAX_R_SIZE words from a presence mask
//               followed by its nonzero words, filling lanes in ascending
//               order and restoring zeros in the empty lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module row_decompressor #(
  parameter int WORD_WIDTH   = rc_pkg::WORD_WIDTH,
  parameter int MAX_R_SIZE   = rc_pkg::MAX_R_SIZE,
  parameter int R_DIST_WIDTH = rc_pkg::R_DIST_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [MAX_R_SIZE-1:0]            mask_in,
  input  logic                             mask_valid,
  output logic                             mask_ready,
  input  logic [WORD_WIDTH-1:0]            data_in,
  input  logic                             data_valid,
  output logic                             data_ready,
  output logic [WORD_WIDTH*MAX_R_SIZE-1:0] data_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  import rc_pkg::*;

  logic [1:0]              state_q, state_d;
  logic [MAX_R_SIZE-1:0]   rem_mask_q, rem_mask_d;
  logic [MAX_R_SIZE-1:0]   lane_we;
  logic [R_DIST_WIDTH-1:0] low_idx;
  logic                    low_any;
  logic                    mask_hs, word_hs, out_hs;

  rc_lowest_set_finder #(
    .MAX_R_SIZE  (MAX_R_SIZE),
    .R_DIST_WIDTH(R_DIST_WIDTH)
  ) u_finder (
    .mask(rem_mask_q),
    .idx (low_idx),
    .any (low_any)
  );

  // Handshake strobes; readys depend only on registered state
  assign mask_hs = (state_q == ST_IDLE) && mask_valid;
  assign word_hs = (state_q == ST_FILL) && data_valid;
  assign out_hs  = (state_q == ST_OUT)  && out_ready;

  assign mask_ready = (state_q == ST_IDLE);
  assign data_ready = (state_q == ST_FILL);
  assign out_valid  = (state_q == ST_OUT);
  assign busy       = (state_q != ST_IDLE);

  // Remaining-mask update and next-state selection
  always_comb begin
    rem_mask_d = rem_mask_q;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mask_hs) begin
          rem_mask_d = mask_in;
          state_d    = (mask_in == '0) ? ST_OUT : ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_hs) begin
          rem_mask_d = rem_mask_q & ~lane_we;
          if (rem_mask_d == '0) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and remaining-mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
    end
  end

  // Per-lane storage: cleared on a new mask, loaded when its lane is next
  for (genvar i = 0; i < MAX_R_SIZE; i++) begin : g_lane
    logic [WORD_WIDTH-1:0] lane_q;

    assign lane_we[i] = word_hs && low_any && (low_idx == R_DIST_WIDTH'(i));

    // Lane data register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lane_q <= '0;
      end else if (mask_hs) begin
        lane_q <= '0;
      end else if (lane_we[i]) begin
        lane_q <= data_in;
      end
    end

    assign data_out[WORD_WIDTH*(i+1)-1:WORD_WIDTH*i] = lane_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_row_decompressor.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_decompressor
// Description : Directed self-checking bench for row_decompressor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_decompressor;

  logic        clk;
  logic        reset_n;
  logic [3:0]  mask_in;
  logic        mask_valid;
  logic        mask_ready;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  row_decompressor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mask_in   (mask_in),
    .mask_valid(mask_valid),
    .mask_ready(mask_ready),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one compressed row with data_valid held high, then check the row
  task automatic do_row(input string tag, input logic [3:0] m, input logic [31:0] words,
                        input int k, input logic [31:0] exp_row);
    int waited;
    mask_in    = m;
    mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
    for (int j = 0; j < k; j++) begin
      data_in    = words[8*j +: 8];
      data_valid = 1'b1;
      step();
    end
    data_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_wait"}, 32'(waited), 32'd0);
    chk({tag, "_row"}, data_out, exp_row);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, mask_ready, busy}, 32'd2);
  endtask

  initial begin
    logic [31:0] held;
    reset_n    = 1'b0;
    mask_in    = '0;
    mask_valid = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    out_ready  = 1'b0;
    #12;
    // Reset state: mask_ready=1, all else 0
    chk("rst_flags", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h8);
    chk("rst_data", data_out, 32'h0);
    #5 reset_n = 1'b1;
    step();

    // Mask 1010, words 1,2: out_valid appears after the third edge
    mask_in = 4'b1010; mask_valid = 1'b1; out_ready = 1'b1;
    step();
    mask_valid = 1'b0;
    chk("t1_fill", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h5);
    data_in = 8'd1; data_valid = 1'b1;
    step();
    chk("t1_ov_early", {31'd0, out_valid}, 32'd0);
    data_in = 8'd2;
    step();
    data_valid = 1'b0;
    chk("t1_ov", {31'd0, out_valid}, 32'd1);
    chk("t1_row", data_out, 32'h02000100);
    step();
    out_ready = 1'b0;
    chk("t1_idle", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h8);
    chk("t1_hold", data_out, 32'h02000100);

    // Round-trip rows
    do_row("t2a", 4'b1100, 32'h00000403, 2, 32'h04030000);
    do_row("t2b", 4'b1011, 32'h00070605, 3, 32'h07000605);
    do_row("t2c", 4'b0100, 32'h00000008, 1, 32'h00080000);

    // All-zero mask: row ready one edge after the mask, no data phase
    mask_in = 4'b0000; mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
    chk("t3_flags", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h3);
    chk("t3_row", data_out, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_idle", {30'd0, mask_ready, busy}, 32'd2);

    // Full mask with gapped data_valid and a stalled output
    mask_in = 4'b1111; mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      data_in    = 8'(9 + j / 2);
      data_valid = (j % 2 == 0);
      step();
      chk("t4_busy", {30'd0, busy, mask_ready}, 32'd2);
    end
    data_valid = 1'b0;
    chk("t4_ov", {31'd0, out_valid}, 32'd1);
    chk("t4_row", data_out, 32'h0C0B0A09);
    held = data_out;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t4_stall", {data_out[31:3], out_valid, busy, mask_ready},
          {held[31:3], 3'b110});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_release", {29'd0, out_valid, busy, mask_ready}, 32'd1);

    // Asynchronous reset in the middle of a row
    mask_in = 4'b0110; mask_valid = 1'b1;
    step();
    mask_valid = 1'b0;
    data_in = 8'hAA; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("t5_partial", data_out, 32'h0000AA00);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_flags", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h8);
    chk("t5_rst_data", data_out, 32'h0);
    #3 reset_n = 1'b1;
    do_row("t5_next", 4'b0001, 32'h000000FF, 1, 32'h000000FF);

    // mask_valid and data_valid together in IDLE: only the mask is taken
    mask_in = 4'b0010; mask_valid = 1'b1;
    data_in = 8'h55; data_valid = 1'b1;
    step();
    mask_valid = 1'b0;
    chk("t6_fill", {28'd0, mask_ready, data_ready, out_valid, busy}, 32'h5);
    chk("t6_nodata", data_out, 32'h0);
    step();
    data_valid = 1'b0;
    chk("t6_ov", {31'd0, out_valid}, 32'd1);
    chk("t6_row", data_out, 32'h00005500);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_idle", {30'd0, mask_ready, busy}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
